// File: rtl/alu_sequencer.sv
// Single-issue sequencer: reads two registers, drives an external ALU, captures
// the result into the register file and presents it on a ready/valid channel.
module alu_sequencer #(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [1:0]       cmd_rs1,
    input  logic [1:0]       cmd_rs2,
    input  logic [1:0]       cmd_rd,
    input  logic             cmd_ci,
    input  logic             ld_en,
    input  logic [1:0]       ld_addr,
    input  logic [WIDTH:0]   ld_data,
    output logic [WIDTH:0]   alu_a,
    output logic [WIDTH:0]   alu_b,
    output logic [1:0]       alu_op,
    output logic             alu_ci,
    input  logic [WIDTH:0]   alu_out,
    input  logic             alu_cero,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH:0]   rsp_data,
    output logic             rsp_zero,
    output logic             busy,
    output logic [7:0]       op_count
);

    typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESP} seqStateT;

    seqStateT       state;
    seqStateT       stateNext;
    logic [WIDTH:0] rf [4];
    logic [1:0]     rdLatch;
    logic           accept;

    // Reset is folded into the status outputs so they read inactive while rst is high.
    assign cmd_ready = (state == IDLE) && !rst;
    assign accept    = cmd_valid && cmd_ready;
    assign rsp_valid = (state == RESP) && !rst;
    assign busy      = (state != IDLE) && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    if (accept) stateNext = ISSUE;
            ISSUE:   stateNext = CAPTURE;
            CAPTURE: stateNext = RESP;
            RESP:    if (rsp_ready) stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    // Operand issue on accept; writeback at the end of CAPTURE. The writeback is
    // placed after the direct load so it wins when both target the same entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                rf[i] <= '0;
            end
            alu_a    <= '0;
            alu_b    <= '0;
            alu_op   <= '0;
            alu_ci   <= 1'b0;
            rdLatch  <= '0;
            rsp_data <= '0;
            rsp_zero <= 1'b0;
            op_count <= '0;
        end else begin
            if (ld_en) begin
                rf[ld_addr] <= ld_data;
            end
            if (accept) begin
                alu_a   <= rf[cmd_rs1];
                alu_b   <= rf[cmd_rs2];
                alu_op  <= cmd_op;
                alu_ci  <= cmd_ci;
                rdLatch <= cmd_rd;
            end
            if (state == CAPTURE) begin
                rf[rdLatch] <= alu_out;
                rsp_data    <= alu_out;
                rsp_zero    <= alu_cero;
                op_count    <= op_count + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a behavioural ALU on the alu_* ports.
module tb_alu_sequencer;

    localparam int WIDTH = 3;

    logic             clk = 1'b0;
    logic             rst;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [1:0]       cmd_rs1;
    logic [1:0]       cmd_rs2;
    logic [1:0]       cmd_rd;
    logic             cmd_ci;
    logic             ld_en;
    logic [1:0]       ld_addr;
    logic [WIDTH:0]   ld_data;
    logic [WIDTH:0]   alu_a;
    logic [WIDTH:0]   alu_b;
    logic [1:0]       alu_op;
    logic             alu_ci;
    logic [WIDTH:0]   alu_out;
    logic             alu_cero;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH:0]   rsp_data;
    logic             rsp_zero;
    logic             busy;
    logic [7:0]       op_count;

    int checks = 0;
    int errors = 0;
    int expCount = 0;

    always #5 clk = ~clk;

    alu_sequencer #(.WIDTH(WIDTH)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_rs1(cmd_rs1), .cmd_rs2(cmd_rs2), .cmd_rd(cmd_rd), .cmd_ci(cmd_ci),
        .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_ci(alu_ci),
        .alu_out(alu_out), .alu_cero(alu_cero),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_zero(rsp_zero), .busy(busy), .op_count(op_count)
    );

    // ALU: add a+b+ci, mult a*b, div a/b (all ones on /0), sub a-b-ci; all modulo 16
    always_comb begin
        alu_out = '0;
        case (alu_op)
            2'd0: alu_out = alu_a + alu_b + {3'b000, alu_ci};
            2'd1: alu_out = alu_a * alu_b;
            2'd2: alu_out = (alu_b == 4'd0) ? 4'hF : alu_a / alu_b;
            2'd3: alu_out = alu_a - alu_b - {3'b000, alu_ci};
            default: alu_out = '0;
        endcase
        alu_cero = (alu_out == 4'd0);
    end

    typedef struct {
        logic [1:0] op;
        logic [3:0] a;
        logic [3:0] b;
        logic       ci;
        logic [1:0] rd;
        logic [3:0] expData;
        logic       expZero;
    } vecT;

    vecT vecs [11];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic loadReg(input logic [1:0] addr, input logic [3:0] data);
        ld_en   = 1'b1;
        ld_addr = addr;
        ld_data = data;
        tick();
        ld_en   = 1'b0;
    endtask

    // Offers a command for one edge; returns one step after the accept edge (ISSUE).
    task automatic acceptCmd(input logic [1:0] op, input logic [1:0] rs1, input logic [1:0] rs2,
                             input logic [1:0] rd, input logic ci);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_rs1   = rs1;
        cmd_rs2   = rs2;
        cmd_rd    = rd;
        cmd_ci    = ci;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic finishRsp();
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    task automatic runVec(input vecT v);
        loadReg(2'd0, v.a);
        loadReg(2'd1, v.b);
        chk("ready_idle", 32'(cmd_ready), 1);
        acceptCmd(v.op, 2'd0, 2'd1, v.rd, v.ci);
        chk("alu_a", 32'(alu_a), 32'(v.a));
        chk("alu_b", 32'(alu_b), 32'(v.b));
        chk("alu_op", 32'(alu_op), 32'(v.op));
        chk("alu_ci", 32'(alu_ci), 32'(v.ci));
        chk("busy_issue", 32'(busy), 1);
        chk("valid_issue", 32'(rsp_valid), 0);
        tick();
        chk("valid_capture", 32'(rsp_valid), 0);
        tick();
        expCount = (expCount + 1) % 256;
        chk("valid_resp", 32'(rsp_valid), 1);
        chk("rsp_data", 32'(rsp_data), 32'(v.expData));
        chk("rsp_zero", 32'(rsp_zero), 32'(v.expZero));
        chk("op_count", 32'(op_count), expCount);
        finishRsp();
        chk("valid_after", 32'(rsp_valid), 0);
        chk("ready_after", 32'(cmd_ready), 1);
        chk("rf_rd", 32'(dut.rf[v.rd]), 32'(v.expData));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{2'd0, 4'd5,  4'd3,  1'b0, 2'd2, 4'd8,  1'b0};
        vecs[1]  = '{2'd1, 4'd3,  4'd5,  1'b0, 2'd3, 4'hF,  1'b0};
        vecs[2]  = '{2'd2, 4'd7,  4'd2,  1'b0, 2'd2, 4'd3,  1'b0};
        vecs[3]  = '{2'd3, 4'd6,  4'd6,  1'b0, 2'd3, 4'd0,  1'b1};
        vecs[4]  = '{2'd0, 4'd9,  4'd7,  1'b0, 2'd2, 4'd0,  1'b1};
        vecs[5]  = '{2'd0, 4'd5,  4'd3,  1'b1, 2'd3, 4'd9,  1'b0};
        vecs[6]  = '{2'd3, 4'd2,  4'd5,  1'b0, 2'd2, 4'hD,  1'b0};
        vecs[7]  = '{2'd1, 4'd4,  4'd4,  1'b0, 2'd3, 4'd0,  1'b1};
        vecs[8]  = '{2'd2, 4'd2,  4'd7,  1'b0, 2'd2, 4'd0,  1'b1};
        vecs[9]  = '{2'd2, 4'hF,  4'd1,  1'b0, 2'd3, 4'hF,  1'b0};
        vecs[10] = '{2'd0, 4'hF,  4'hF,  1'b1, 2'd2, 4'hF,  1'b0};

        // Reset with command and load offered: both must be ignored
        rst = 1'b1; cmd_valid = 1'b1; cmd_op = 2'd1; cmd_rs1 = 2'd0; cmd_rs2 = 2'd0;
        cmd_rd = 2'd0; cmd_ci = 1'b1; ld_en = 1'b1; ld_addr = 2'd2; ld_data = 4'd9;
        rsp_ready = 1'b0;
        tick();
        tick();
        chk("rst_ready", 32'(cmd_ready), 0);
        chk("rst_valid", 32'(rsp_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        rst = 1'b0; cmd_valid = 1'b0; ld_en = 1'b0;
        #1;
        chk("rst_opcount", 32'(op_count), 0);
        chk("rst_alu_a", 32'(alu_a), 0);
        chk("rst_alu_ci", 32'(alu_ci), 0);
        chk("rst_rsp_data", 32'(rsp_data), 0);
        chk("rst_rf2", 32'(dut.rf[2]), 0);
        chk("rst_ready_rel", 32'(cmd_ready), 1);

        for (int i = 0; i < 11; i++) begin
            runVec(vecs[i]);
        end

        // Response held off: output stable, new command ignored
        loadReg(2'd0, 4'd6);
        loadReg(2'd1, 4'd6);
        acceptCmd(2'd3, 2'd0, 2'd1, 2'd3, 1'b0);
        tick();
        tick();
        expCount = (expCount + 1) % 256;
        cmd_valid = 1'b1; cmd_op = 2'd0; cmd_rs1 = 2'd2; cmd_rs2 = 2'd2; cmd_rd = 2'd1;
        for (int i = 0; i < 5; i++) begin
            chk("hold_valid", 32'(rsp_valid), 1);
            chk("hold_data", 32'(rsp_data), 0);
            chk("hold_zero", 32'(rsp_zero), 1);
            chk("hold_ready", 32'(cmd_ready), 0);
            if (i < 4) tick();
        end
        cmd_valid = 1'b0;
        finishRsp();
        chk("hold_exit", 32'(rsp_valid), 0);
        chk("hold_alu_a", 32'(alu_a), 6);
        chk("hold_alu_op", 32'(alu_op), 3);
        chk("hold_count", 32'(op_count), expCount);

        // Load and writeback to the same entry at the CAPTURE edge
        loadReg(2'd0, 4'd2);
        loadReg(2'd1, 4'd3);
        acceptCmd(2'd0, 2'd0, 2'd1, 2'd1, 1'b0);
        tick();
        ld_en = 1'b1; ld_addr = 2'd1; ld_data = 4'd9;
        tick();
        ld_en = 1'b0;
        expCount = (expCount + 1) % 256;
        chk("wb_data", 32'(rsp_data), 5);
        chk("wb_wins", 32'(dut.rf[1]), 5);
        finishRsp();

        // Load to a source register in the accept cycle
        loadReg(2'd0, 4'd4);
        loadReg(2'd1, 4'd1);
        ld_en = 1'b1; ld_addr = 2'd0; ld_data = 4'd7;
        acceptCmd(2'd0, 2'd0, 2'd1, 2'd2, 1'b0);
        ld_en = 1'b0;
        chk("old_src_a", 32'(alu_a), 4);
        chk("ld_applied", 32'(dut.rf[0]), 7);
        tick();
        tick();
        expCount = (expCount + 1) % 256;
        chk("old_src_data", 32'(rsp_data), 5);
        finishRsp();
        chk("old_src_rf2", 32'(dut.rf[2]), 5);

        // Reset during CAPTURE aborts the operation
        loadReg(2'd0, 4'd3);
        loadReg(2'd1, 4'd3);
        acceptCmd(2'd0, 2'd0, 2'd1, 2'd3, 1'b0);
        tick();
        rst = 1'b1;
        #1;
        chk("abort_busy_rst", 32'(busy), 0);
        chk("abort_ready_rst", 32'(cmd_ready), 0);
        tick();
        rst = 1'b0;
        #1;
        expCount = 0;
        chk("abort_busy", 32'(busy), 0);
        chk("abort_ready", 32'(cmd_ready), 1);
        chk("abort_count", 32'(op_count), 0);
        for (int i = 0; i < 4; i++) begin
            chk("abort_rf", 32'(dut.rf[i]), 0);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("abort_novalid", 32'(rsp_valid), 0);
        end

        // op_count wrap
        loadReg(2'd0, 4'd1);
        loadReg(2'd1, 4'd1);
        for (int i = 0; i < 256; i++) begin
            acceptCmd(2'd0, 2'd0, 2'd1, 2'd2, 1'b0);
            tick();
            tick();
            if (i == 254) chk("count_255", 32'(op_count), 255);
            finishRsp();
        end
        chk("count_wrap", 32'(op_count), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 Parameter: WIDTH, default 3, data width is WIDTH+1 bits (MSB index WIDTH).
REQ-002 Port: clk  in  1  sole clock; all state updates on rising edge.
REQ-003 Port: rst  in  1  synchronous, active-high reset.
REQ-004 Port: cmd_valid  in  1  command offered.
REQ-005 Port: cmd_ready  out  1  sequencer can accept a command.
REQ-006 Port: cmd_op  in  2  00 add, 01 mult, 10 div, 11 sub.
REQ-007 Port: cmd_rs1, cmd_rs2, cmd_rd  in  2 each  source and destination register indices.
REQ-008 Port: cmd_ci  in  1  carry-in for the operation.
REQ-009 Port: ld_en  in  1; ld_addr  in  2; ld_data  in  WIDTH+1  direct register-file load.
REQ-010 Port: alu_a, alu_b  out  WIDTH+1; alu_op  out  2; alu_ci  out  1  drive ALU inputs.
REQ-011 Port: alu_out  in  WIDTH+1; alu_cero  in  1  ALU result and zero flag.
REQ-012 Port: rsp_valid  out  1; rsp_ready  in  1; rsp_data  out  WIDTH+1; rsp_zero  out  1  result channel.
REQ-013 Port: busy  out  1  high whenever state is not IDLE.
REQ-014 Port: op_count  out  8  completed-operation counter.

Function
REQ-015 Register file SHALL hold 4 entries of WIDTH+1 bits.
REQ-016 FSM SHALL have states IDLE, ISSUE, CAPTURE, RESP.
REQ-017 cmd_ready SHALL be 1 only in IDLE with rst low; accept = cmd_valid && cmd_ready at edge T.
REQ-018 On accept: latch rf[rs1], rf[rs2] (pre-edge values), op, ci, rd; state -> ISSUE.
REQ-019 alu_a/alu_b/alu_op/alu_ci SHALL be registered, updated only on accept, held until the next accept.
REQ-020 ISSUE lasts exactly one cycle (T+1); state -> CAPTURE.
REQ-021 At edge ending CAPTURE (T+2 to T+3 boundary): sample alu_out, alu_cero into rsp_data, rsp_zero, write alu_out into rf[rd], increment op_count, state -> RESP.
REQ-022 rsp_valid SHALL be 1 exactly while in RESP; command-accept to rsp_valid high = 3 cycles.
REQ-023 rsp_data/rsp_zero SHALL stay stable while rsp_valid && !rsp_ready.
REQ-024 RESP -> IDLE at edge where rsp_ready = 1; rsp_ready ignored outside RESP.
REQ-025 No back-to-back overlap: next command accepted no earlier than the cycle after RESP exit.
REQ-026 ld_en SHALL write ld_data into rf[ld_addr] at the edge, in any state.
REQ-027 ld_en and CAPTURE writeback to the same index at the same edge: writeback wins.
REQ-028 ld_en to a source register in the accept cycle: the accept latches the old value.
REQ-029 op_count wraps 255 -> 0; result bits beyond WIDTH are never produced (ALU output width only).
REQ-030 cmd_* fields SHALL be ignored when cmd_ready = 0.

Reset
REQ-031 rst high at an edge: state IDLE, all rf entries 0, alu_a/alu_b/alu_op/alu_ci 0, rsp_data 0, rsp_zero 0, op_count 0.
REQ-032 While rst high: cmd_ready 0, rsp_valid 0, busy 0; ld_en and cmd_valid ignored.
REQ-033 rst mid-operation (ISSUE/CAPTURE/RESP) SHALL abort it: no rf writeback, no op_count increment, pending response dropped.

Verification (WIDTH=3, bench instantiates the team ALU on alu_* ports)
REQ-034 Load rf0=5, rf1=3; add rd=2 ci=0 -> rsp_valid 3 cycles after accept, rsp_data=8, rsp_zero=0, rf2=8, op_count=1.
REQ-035 rf0=3, rf1=5, mult rd=3 -> rsp_data=4'hF; then div 7/2 (rf0=7, rf1=2) -> rsp_data=3.
REQ-036 Sub rf0=rf1=6 -> rsp_data=0, rsp_zero=1; hold rsp_ready=0 for 4 cycles -> rsp_valid, data stable, cmd_ready=0 throughout.
REQ-037 ld_en to rd during CAPTURE edge with ld_data=9 -> rf[rd]=ALU result, not 9; ld to rs1 in accept cycle -> old value used.
REQ-038 Assert rst during CAPTURE -> next cycle IDLE, rsp_valid never rises, rf all 0, op_count 0.
REQ-039 Run 256 ops -> op_count returns to 0.
